// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_t : FSM encodings (IDLE, ISSUE, CAPTURE, DONE)
//   gnt_t   : requester ids (GNT_M0 = CPU, GNT_M1 = debug/display)
//   ADDR_W / DATA_W / BE_W : RAM word address, data and byte-enable widths
package dmem_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } gnt_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin selector (purely combinational).
//   req    : request lines, bit 0 = m0, bit 1 = m1
//   last   : requester granted most recently
//   winner : requester to grant now; meaningful only when any req is high
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  gnt_t       last,
    output gnt_t       winner
);

    always_comb begin
        winner = GNT_M0;
        if (req[1] && req[0]) begin
            // Tie: the side not served last goes first.
            winner = (last == GNT_M0) ? GNT_M1 : GNT_M0;
        end else if (req[1]) begin
            winner = GNT_M1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous single-port data RAM between two requesters.
// Every access takes a fixed four-cycle slot: IDLE (arbitrate + latch),
// ISSUE (drive RAM), CAPTURE (register read data), DONE (ack pulse).
//   clk, rst                  : clock, synchronous active-high reset
//   m0_* / m1_*               : requester ports (req/wen/addr/wdata in,
//                               ack/rdata out); wen==0 means read
//   ram_wen/ram_addr/ram_wdata: RAM command outputs
//   ram_rdata                 : RAM read data, one cycle after address
module dmem_arbiter
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [BE_W-1:0]   m0_wen,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic [BE_W-1:0]   m1_wen,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [BE_W-1:0]   ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t              state_q, state_d;
    gnt_t                last_q;
    gnt_t                gnt_q;
    gnt_t                winner;
    logic                latch_en;
    logic                capture_en;
    logic [BE_W-1:0]     wen_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   m0_rdata_q;
    logic [DATA_W-1:0]   m1_rdata_q;

    rr_arb2 u_rr (
        .req    ({m1_req, m0_req}),
        .last   (last_q),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        latch_en   = 1'b0;
        capture_en = 1'b0;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;
        ram_wen    = '0;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    latch_en = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // Gated by rst so a reset edge landing here never writes.
                ram_wen = rst ? '0 : wen_q;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                capture_en = (wen_q == '0);
                state_d    = DONE;
            end
            DONE: begin
                m0_ack  = !rst && (gnt_q == GNT_M0);
                m1_ack  = !rst && (gnt_q == GNT_M1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= GNT_M1;
            gnt_q      <= GNT_M0;
            wen_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            if (latch_en) begin
                last_q  <= winner;
                gnt_q   <= winner;
                wen_q   <= (winner == GNT_M1) ? m1_wen   : m0_wen;
                addr_q  <= (winner == GNT_M1) ? m1_addr  : m0_addr;
                wdata_q <= (winner == GNT_M1) ? m1_wdata : m0_wdata;
            end
            if (capture_en) begin
                rdata_q <= ram_rdata;
            end
            // Remember what each port showed on its ack so it holds afterwards.
            if (m0_ack) begin
                m0_rdata_q <= rdata_q;
            end
            if (m1_ack) begin
                m1_rdata_q <= rdata_q;
            end
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign m0_rdata  = m0_ack ? rdata_q : m0_rdata_q;
    assign m1_rdata  = m1_ack ? rdata_q : m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural synchronous RAM.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req;
    logic [3:0]  m0_wen, m1_wen;
    logic [4:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [3:0]  ram_wen;
    logic [4:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_load;

    logic [31:0] mem [32];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        bit          id;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] m0_hold, m1_hold;

    dmem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_wen    (m0_wen),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_wen    (m1_wen),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM, contents index+1 after load.
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= i + 1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_wen[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per ack cycle.
    always @(negedge clk) begin
        if (rst) begin
            m0_hold = 32'd0;
            m1_hold = 32'd0;
        end else if (m0_ack || m1_ack) begin
            exp_t e;
            chk("ack_exclusive", {31'd0, m0_ack & m1_ack}, 32'd0);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack actual=m0:%0b m1:%0b required=none (cycle %0d)",
                         m0_ack, m1_ack, cyc);
            end else begin
                e = sbq.pop_front();
                chk("ack_id", {31'd0, m1_ack}, {31'd0, e.id});
                chk("ack_cycle", cyc, e.cyc);
                if (m1_ack) begin
                    chk("m1_rdata", m1_rdata, e.data);
                    chk("m0_rdata_hold", m0_rdata, m0_hold);
                    m1_hold = e.data;
                end else begin
                    chk("m0_rdata", m0_rdata, e.data);
                    chk("m1_rdata_hold", m1_rdata, m1_hold);
                    m0_hold = e.data;
                end
            end
        end
    end

    task automatic wait_ack(input bit id);
        int n = 0;
        while (!(id ? m1_ack : m0_ack) && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!(id ? m1_ack : m0_ack)) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout actual=no ack required=ack on m%0d", id);
        end
    endtask

    task automatic drive(input bit id, input logic [3:0] wen, input logic [4:0] addr,
                         input logic [31:0] wdata);
        if (id) begin
            m1_req = 1'b1; m1_wen = wen; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_wen = wen; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    // Called at a negedge while the DUT is idle; returns at the next idle negedge.
    task automatic access(input bit id, input logic [3:0] wen, input logic [4:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp);
        drive(id, wen, addr, wdata);
        sbq.push_back('{id: id, data: exp, cyc: cyc + 3});
        wait_ack(id);
        if (id) m1_req = 1'b0; else m0_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; ram_load = 1'b1;
        m0_req = 0; m0_wen = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wen = 0; m1_addr = 0; m1_wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m0_ack",    {31'd0, m0_ack}, 32'd0);
        chk("rst_m1_ack",    {31'd0, m1_ack}, 32'd0);
        chk("rst_m0_rdata",  m0_rdata, 32'd0);
        chk("rst_m1_rdata",  m1_rdata, 32'd0);
        chk("rst_ram_addr",  {27'd0, ram_addr}, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_ram_wen",   {28'd0, ram_wen}, 32'd0);
        rst = 1'b0; ram_load = 1'b0;
        @(negedge clk);

        // m0 read of addr 5 -> 6
        access(0, 4'b0000, 5'd5, 32'd0, 32'd6);
        // m1 partial write; ack shows the retained rdata_q (6), then read back
        access(1, 4'b0011, 5'd3, 32'hAABBCCDD, 32'd6);
        access(1, 4'b0000, 5'd3, 32'd0, 32'h0000CCDD);

        // m1 changes address after latch: still reads addr 2
        drive(1, 4'b0000, 5'd2, 32'd0);
        sbq.push_back('{id: 1'b1, data: 32'd3, cyc: cyc + 3});
        @(negedge clk);
        m1_addr = 5'd9;
        wait_ack(1);
        m1_req = 1'b0;
        @(negedge clk);

        // Both held for four accesses: m0, m1, m0, m1
        drive(0, 4'b0000, 5'd10, 32'd0);
        drive(1, 4'b0000, 5'd11, 32'd0);
        sbq.push_back('{id: 1'b0, data: 32'd11, cyc: cyc + 3});
        sbq.push_back('{id: 1'b1, data: 32'd12, cyc: cyc + 7});
        sbq.push_back('{id: 1'b0, data: 32'd11, cyc: cyc + 11});
        sbq.push_back('{id: 1'b1, data: 32'd12, cyc: cyc + 15});
        repeat (15) @(negedge clk);
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);

        // m0 keeps req high through DONE: back-to-back accesses 4 cycles apart
        drive(0, 4'b0000, 5'd0, 32'd0);
        sbq.push_back('{id: 1'b0, data: 32'd1, cyc: cyc + 3});
        sbq.push_back('{id: 1'b0, data: 32'd1, cyc: cyc + 7});
        wait_ack(0);
        @(negedge clk);
        wait_ack(0);
        m0_req = 1'b0;
        @(negedge clk);

        // Reset during ISSUE of an m0 full write to addr 7
        drive(0, 4'b1111, 5'd7, 32'hFFFFFFFF);
        @(negedge clk);
        rst = 1'b1;
        m0_req = 1'b0;
        #1;
        chk("rst_in_issue_ram_wen", {28'd0, ram_wen}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            chk("no_ack_after_abort", {30'd0, m1_ack, m0_ack}, 32'd0);
            n++;
        end
        access(0, 4'b0000, 5'd7, 32'd0, 32'd8);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
